// File: rtl/xgmac_rx_frame_fifo.sv
// Store-and-forward RX frame buffer: commits whole frames only, drops (and counts) frames that overflow.
// Latency: last input beat at cycle N commits at N+1; first output beat valid at N+3.
// Backpressure: none on ingress (overflow drops the frame); m_axis_rready stalls egress via output reg + 1-entry skid.
module xgmac_rx_frame_fifo #(
    parameter int P_ADDR_WIDTH      = 9,
    parameter int P_INFO_ADDR_WIDTH = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [63:0]             s_axis_rdata,
    input  logic [79:0]             s_axis_ruser,
    input  logic [7:0]              s_axis_rkeep,
    input  logic                    s_axis_rlast,
    input  logic                    s_axis_rvalid,
    output logic [63:0]             m_axis_rdata,
    output logic [79:0]             m_axis_ruser,
    output logic [7:0]              m_axis_rkeep,
    output logic                    m_axis_rlast,
    output logic                    m_axis_rvalid,
    input  logic                    m_axis_rready,
    output logic [15:0]             o_drop_cnt,
    output logic [P_ADDR_WIDTH:0]   o_fifo_words
);
    localparam int PW        = P_ADDR_WIDTH + 1;
    localparam int IPW       = P_INFO_ADDR_WIDTH + 1;
    localparam int LP_DEPTH  = 1 << P_ADDR_WIDTH;
    localparam int LP_IDEPTH = 1 << P_INFO_ADDR_WIDTH;
    localparam logic [PW-1:0]  LP_FULL  = PW'(LP_DEPTH);
    localparam logic [IPW-1:0] LP_IFULL = IPW'(LP_IDEPTH);
    localparam logic [PW-1:0]  LP_ONE   = PW'(1);
    localparam logic [IPW-1:0] LP_IONE  = IPW'(1);

    typedef enum logic [1:0] {ST_IDLE, ST_RECV, ST_DROP} state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_wr_commit;
    logic [PW-1:0]   r_rd_ptr;      // advances on output handshake; frees space
    logic [PW-1:0]   r_raddr;       // prefetch address into the RAM
    logic [72:0]     r_mem [LP_DEPTH];
    logic [72:0]     r_ram_q;
    logic            r_ram_vld;

    logic [79:0]     r_ruser_lat;
    logic [79:0]     r_info_mem [LP_IDEPTH];
    logic [IPW-1:0]  r_info_wp;
    logic [IPW-1:0]  r_info_rp;

    logic [72:0]     r_out_dat;
    logic            r_out_vld;
    logic [72:0]     r_skid_dat;
    logic            r_skid_vld;
    logic [15:0]     r_drop_cnt;

    logic            w_space;
    logic            w_info_full;
    logic            w_wr_en;
    logic            w_commit;
    logic            w_rollback;
    logic            w_drop;
    logic [7:0]      w_keep;
    logic [79:0]     w_info_din;
    logic            w_hs;
    logic            w_pop_info;
    logic [1:0]      w_inflight;
    logic            w_rd_issue;

    assign w_space     = (r_wr_ptr - r_rd_ptr) != LP_FULL;
    assign w_info_full = (r_info_wp - r_info_rp) == LP_IFULL;
    assign w_keep      = s_axis_rlast ? s_axis_rkeep : 8'hFF;
    // A single-beat frame commits straight from IDLE, before ruser could be latched.
    assign w_info_din  = (r_state == ST_IDLE) ? s_axis_ruser : r_ruser_lat;

    // Ingress state register
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Ingress next-state: frame accept / drop decisions
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (s_axis_rvalid && !s_axis_rlast)
                    w_state_nxt = (w_info_full || !w_space) ? ST_DROP : ST_RECV;
            end
            ST_RECV: begin
                if (s_axis_rvalid) begin
                    if (s_axis_rlast)  w_state_nxt = ST_IDLE;
                    else if (!w_space) w_state_nxt = ST_DROP;
                end
            end
            ST_DROP: begin
                if (s_axis_rvalid && s_axis_rlast) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Ingress outputs: RAM write, commit, rollback and drop strobes
    always_comb begin
        w_wr_en    = 1'b0;
        w_commit   = 1'b0;
        w_rollback = 1'b0;
        w_drop     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (s_axis_rvalid) begin
                    if (!w_info_full && w_space) begin
                        w_wr_en  = 1'b1;
                        w_commit = s_axis_rlast;
                    end else begin
                        w_drop   = 1'b1;
                    end
                end
            end
            ST_RECV: begin
                if (s_axis_rvalid) begin
                    if (w_space) begin
                        w_wr_en    = 1'b1;
                        w_commit   = s_axis_rlast;
                    end else begin
                        w_rollback = 1'b1;
                        w_drop     = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Write-side pointers and per-frame ruser latch
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_wr_ptr    <= '0;
            r_wr_commit <= '0;
            r_ruser_lat <= '0;
        end else begin
            if (w_wr_en)         r_wr_ptr <= r_wr_ptr + LP_ONE;
            else if (w_rollback) r_wr_ptr <= r_wr_commit;
            if (w_commit)        r_wr_commit <= r_wr_ptr + LP_ONE;
            if (w_wr_en && (r_state == ST_IDLE)) r_ruser_lat <= s_axis_ruser;
        end
    end

    // Data RAM write port
    always_ff @(posedge i_clk) begin
        if (w_wr_en) r_mem[r_wr_ptr[P_ADDR_WIDTH-1:0]] <= {s_axis_rlast, w_keep, s_axis_rdata};
    end

    // Saturating dropped-frame counter
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst)                               r_drop_cnt <= '0;
        else if (w_drop && r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
    end

    assign w_hs       = r_out_vld && m_axis_rready;
    assign w_pop_info = w_hs && r_out_dat[72];

    // Info FIFO storage: one ruser per committed frame
    always_ff @(posedge i_clk) begin
        if (w_commit) r_info_mem[r_info_wp[P_INFO_ADDR_WIDTH-1:0]] <= w_info_din;
    end

    // Info FIFO pointers: push on commit, pop on last-beat handshake
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_info_wp <= '0;
            r_info_rp <= '0;
        end else begin
            if (w_commit)   r_info_wp <= r_info_wp + LP_IONE;
            if (w_pop_info) r_info_rp <= r_info_rp + LP_IONE;
        end
    end

    // Beats in RAM-read stage, output reg and skid never exceed two, so the skid cannot overflow.
    assign w_inflight = {1'b0, r_ram_vld} + {1'b0, r_out_vld} + {1'b0, r_skid_vld};
    assign w_rd_issue = (r_raddr != r_wr_commit) && ((w_inflight != 2'd2) || w_hs);

    // Read-side pointers and RAM read-valid stage
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_raddr   <= '0;
            r_rd_ptr  <= '0;
            r_ram_vld <= 1'b0;
        end else begin
            if (w_rd_issue) r_raddr  <= r_raddr + LP_ONE;
            if (w_hs)       r_rd_ptr <= r_rd_ptr + LP_ONE;
            r_ram_vld <= w_rd_issue;
        end
    end

    // Data RAM read port
    always_ff @(posedge i_clk) begin
        if (w_rd_issue) r_ram_q <= r_mem[r_raddr[P_ADDR_WIDTH-1:0]];
    end

    // Output register with one-entry skid absorbing the in-flight RAM read
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_out_vld  <= 1'b0;
            r_out_dat  <= '0;
            r_skid_vld <= 1'b0;
            r_skid_dat <= '0;
        end else if (!r_out_vld || w_hs) begin
            if (r_skid_vld) begin
                r_out_dat  <= r_skid_dat;
                r_out_vld  <= 1'b1;
                r_skid_vld <= 1'b0;
            end else begin
                r_out_vld  <= r_ram_vld;
                if (r_ram_vld) r_out_dat <= r_ram_q;
            end
        end else if (r_ram_vld) begin
            r_skid_vld <= 1'b1;
            r_skid_dat <= r_ram_q;
        end
    end

    assign m_axis_rvalid = r_out_vld;
    assign m_axis_rlast  = r_out_dat[72];
    assign m_axis_rkeep  = r_out_dat[71:64];
    assign m_axis_rdata  = r_out_dat[63:0];
    assign m_axis_ruser  = r_out_vld ? r_info_mem[r_info_rp[P_INFO_ADDR_WIDTH-1:0]] : '0;
    assign o_drop_cnt    = r_drop_cnt;
    assign o_fifo_words  = r_wr_commit - r_rd_ptr;

endmodule
